spectrum_shift_out: RTL and testbench
=====================================

Name: spectrum_shift_out

Overview:
- Downstream stage of the per-bin magnitude quantiser.
- Consumes the packed 16-bin × 2-bit level word (`raise_data`, `raise_valid`, `raise_fin`).
- Expands each level to a 3-LED thermometer code and shifts the resulting 48-bit frame serially to an external shift-register LED bar (clock/data/latch).
- Re-sends only when the level word changes, so the display tracks the spectrum without redundant traffic.

Parameters:
- CLK_DIV, 4, system clocks per serial bit; even, ≥2.
- NUM_BINS, 16, number of frequency bins in `raise_data`.
- BITS_PER_BIN, 3, thermometer LEDs per bin; frame length FRAME_BITS = NUM_BINS*BITS_PER_BIN = 48.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- raise_valid  input  1  level word valid (level-held by upstream once set).
- raise_data  input  32  packed levels; bin k = `raise_data[2k+1:2k]`.
- raise_fin  input  1  upstream finished; forces blank display.
- ser_data  output  1  serial LED data, MSB of frame first.
- ser_clk  output  1  serial shift clock; data sampled externally on rising edge.
- ser_latch  output  1  storage-register latch pulse.
- busy  output  1  high from LOAD through end of LATCH.
- frame_cnt  output  8  frames sent, wraps 255→0.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE; ser_data=0, ser_clk=0, ser_latch=0, busy=0, frame_cnt=0; shadow word=0; sent_once=0; bit and divider counters=0.
- A reset asserted mid-frame aborts the frame immediately. No latch pulse is issued, so the external display keeps its old content.
- Thermometer encoding per bin: level 0→000, 1→001, 2→011, 3→111.
- Frame order: bin 15 first down to bin 0; within a bin, thermometer bit2 first. Frame bit 47 is bin15.bit2.
- Target word: all zeros if `raise_fin`=1, else `raise_data`.

State machine (IDLE, LOAD, SHIFT, LATCH):
- IDLE → LOAD when (`raise_valid`=1 or `raise_fin`=1) and (target ≠ shadow or sent_once=0). Otherwise stay in IDLE.
- LOAD (1 cycle):
  - shadow←target; 48-bit shift register←encoded target; bit_cnt←47; div_cnt←0; busy=1.
  - → SHIFT.
- SHIFT:
  - div_cnt counts 0..CLK_DIV-1.
  - ser_data = shift-register MSB, held for the whole bit period.
  - ser_clk=0 for div_cnt < CLK_DIV/2, 1 otherwise (rising edge mid-bit).
  - At div_cnt=CLK_DIV-1: shift left one; if bit_cnt=0 → LATCH, else bit_cnt−1.
- LATCH:
  - ser_clk=0, ser_latch=1 for exactly CLK_DIV cycles.
  - Then frame_cnt+1, sent_once←1, busy←0 → IDLE.
  - ser_data returns to 0 in LATCH and IDLE.

Timing:
- Busy duration per frame = 1 + 48*CLK_DIV + CLK_DIV cycles (197 at default).
- First ser_clk rise occurs CLK_DIV/2 cycles after SHIFT entry.

Boundary conditions:
- Input changes during LOAD/SHIFT/LATCH are ignored. The comparison is re-evaluated in the first IDLE cycle after LATCH, so a change that arrived mid-frame triggers exactly one follow-up frame.
- `raise_fin` and a data change together: the blank frame wins.
- `raise_valid`=0 and `raise_fin`=0: no transmission, even if `raise_data` toggles.
- Identical words presented repeatedly: sent once only.

Decomposition:
- Package spectrum_pkg:
  - state enum (IDLE/LOAD/SHIFT/LATCH)
  - NUM_BINS, BITS_PER_BIN, FRAME_BITS
  - thermometer constants (THERM_L0..L3 = 3'b000/001/011/111)
- Sub-module spectrum_therm_enc: combinational 32-bit packed levels → 48-bit ordered frame. Instantiated once and fed from the target mux.

Test Plan:
- Reset then `raise_valid`=1, `raise_data`=32'h0000_0000 → one frame, 48 zeros shifted, one ser_latch pulse of 4 cycles, busy 197 cycles, frame_cnt=1.
- `raise_data`=32'hC000_0001 (bin15=3, bin0=1) → captured bits: first three 1,1,1; last three 0,0,1; all others 0; frame_cnt increments.
- Same word held for 1000 cycles after the frame → no further ser_clk edges; frame_cnt unchanged.
- Word changes to 32'h5555_5555 at cycle 50 of a frame in progress → current frame completes unchanged, next frame (16× "001") starts at the first IDLE cycle; frame_cnt +2 total.
- `raise_fin`=1 with `raise_data`=32'hFFFF_FFFF → blank frame (48 zeros) sent once; subsequent FFFF_FFFF ignored while fin held.
- `rst` asserted at cycle 100 of a frame → next cycle all outputs 0, no ser_latch pulse; after release with same word, a full frame is re-sent (sent_once cleared).

Source files
------------

// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum LED shift-out path.
//   - state_t      : frame sender states
//   - NUM_BINS / BITS_PER_BIN / FRAME_BITS : frame geometry
//   - THERM_L0..L3 : per-bin thermometer codes
//   - therm()      : 2-bit level to 3-LED thermometer
package spectrum_pkg;

   localparam int unsigned NUM_BINS     = 16;
   localparam int unsigned BITS_PER_BIN = 3;
   localparam int unsigned LEVEL_W      = 2;
   localparam int unsigned WORD_W       = NUM_BINS * LEVEL_W;
   localparam int unsigned FRAME_BITS   = NUM_BINS * BITS_PER_BIN;

   localparam logic [BITS_PER_BIN-1:0] THERM_L0 = 3'b000;
   localparam logic [BITS_PER_BIN-1:0] THERM_L1 = 3'b001;
   localparam logic [BITS_PER_BIN-1:0] THERM_L2 = 3'b011;
   localparam logic [BITS_PER_BIN-1:0] THERM_L3 = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      LATCH = 2'd3
   } state_t;

   function automatic logic [BITS_PER_BIN-1:0] therm(input logic [LEVEL_W-1:0] lvl);
      logic [BITS_PER_BIN-1:0] code;
      case (lvl)
         2'd0:    code = THERM_L0;
         2'd1:    code = THERM_L1;
         2'd2:    code = THERM_L2;
         default: code = THERM_L3;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/spectrum_therm_enc.sv
// Combinational encoder: packed 16x2-bit levels -> 48-bit LED frame.
// Bin k occupies frame[3k+2:3k], so frame[47] is bin 15 thermometer bit 2.
//   levels  : packed levels, bin k = levels[2k+1:2k]
//   frame_c : thermometer frame, MSB shifted out first
module spectrum_therm_enc
   import spectrum_pkg::*;
(
   input  logic [WORD_W-1:0]     levels,
   output logic [FRAME_BITS-1:0] frame_c
);

   always_comb begin
      frame_c = '0;
      for (int k = 0; k < NUM_BINS; k++) begin
         frame_c[k*BITS_PER_BIN +: BITS_PER_BIN] = therm(levels[k*LEVEL_W +: LEVEL_W]);
      end
   end

endmodule

// File: rtl/spectrum_shift_out.sv
// Serialises the quantised spectrum level word to a shift-register LED bar.
// A frame is sent only when the target word differs from the last one sent
// (or nothing has been sent since reset); raise_fin forces a blank frame.
//   clk, rst     : clock, synchronous active-high reset
//   raise_valid  : level word valid
//   raise_data   : packed 16x2-bit levels
//   raise_fin    : upstream finished, display blanked
//   ser_data     : serial data, frame MSB first
//   ser_clk      : shift clock, rises mid-bit
//   ser_latch    : storage latch pulse, CLK_DIV cycles
//   busy         : high from LOAD through end of LATCH
//   frame_cnt    : frames completed, wraps
module spectrum_shift_out
   import spectrum_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        raise_valid,
   input  logic [31:0] raise_data,
   input  logic        raise_fin,
   output logic        ser_data,
   output logic        ser_clk,
   output logic        ser_latch,
   output logic        busy,
   output logic [7:0]  frame_cnt
);

   localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = $clog2(FRAME_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(FRAME_BITS - 1);

   state_t                  state;
   logic [WORD_W-1:0]       shadow;
   logic                    sent_once;
   logic [FRAME_BITS-1:0]   shreg;
   logic [BIT_W-1:0]        bit_cnt;
   logic [DIV_W-1:0]        div_cnt;

   logic [WORD_W-1:0]       target_c;
   logic [FRAME_BITS-1:0]   enc_c;
   logic [DIV_W-1:0]        div_nxt_c;
   logic                    start_c;

   // Blank frame takes priority over any data change.
   assign target_c  = raise_fin ? '0 : raise_data;
   assign div_nxt_c = div_cnt + DIV_W'(1);
   assign start_c   = (raise_valid | raise_fin) & ((target_c != shadow) | ~sent_once);

   spectrum_therm_enc u_enc (
      .levels  (target_c),
      .frame_c (enc_c)
   );

   // Frame sender; outputs are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shadow    <= '0;
         sent_once <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         ser_data  <= 1'b0;
         ser_clk   <= 1'b0;
         ser_latch <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               ser_data  <= 1'b0;
               ser_clk   <= 1'b0;
               ser_latch <= 1'b0;
               if (start_c) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end

            LOAD: begin
               shadow   <= target_c;
               shreg    <= enc_c;
               bit_cnt  <= BIT_TOP;
               div_cnt  <= '0;
               ser_data <= enc_c[FRAME_BITS-1];
               ser_clk  <= 1'b0;
               state    <= SHIFT;
            end

            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  ser_clk <= 1'b0;
                  shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                  if (bit_cnt == '0) begin
                     state     <= LATCH;
                     ser_data  <= 1'b0;
                     ser_latch <= 1'b1;
                  end else begin
                     bit_cnt  <= bit_cnt - BIT_W'(1);
                     // Next bit is what becomes MSB after this shift.
                     ser_data <= shreg[FRAME_BITS-2];
                  end
               end else begin
                  div_cnt <= div_nxt_c;
                  ser_clk <= (div_nxt_c >= DIV_HALF);
               end
            end

            LATCH: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt   <= '0;
                  ser_latch <= 1'b0;
                  busy      <= 1'b0;
                  frame_cnt <= frame_cnt + 8'd1;
                  sent_once <= 1'b1;
                  state     <= IDLE;
               end else begin
                  div_cnt <= div_nxt_c;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spectrum_shift_out.sv
// Scoreboard bench for spectrum_shift_out: expected frames are queued when
// stimulus is applied; a negedge monitor reassembles frames from ser_clk
// rising edges and queues them on each latch pulse.
module tb_spectrum_shift_out;

   logic        clk = 1'b0;
   logic        rst;
   logic        raise_valid;
   logic [31:0] raise_data;
   logic        raise_fin;
   logic        ser_data;
   logic        ser_clk;
   logic        ser_latch;
   logic        busy;
   logic [7:0]  frame_cnt;

   always #5 clk = ~clk;

   spectrum_shift_out #(.CLK_DIV(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .raise_valid (raise_valid),
      .raise_data  (raise_data),
      .raise_fin   (raise_fin),
      .ser_data    (ser_data),
      .ser_clk     (ser_clk),
      .ser_latch   (ser_latch),
      .busy        (busy),
      .frame_cnt   (frame_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [47:0] exp_q[$];
   logic [47:0] got_q[$];
   int          bits_q[$];

   // Monitor state
   logic [47:0] cap = '0;
   int  nbits = 0;
   int  clk_rises = 0;
   int  latch_run = 0, last_latch = 0;
   int  busy_run = 0, last_busy = 0;
   int  idle_run = 0, last_gap = 0;
   bit  prev_sclk = 0, prev_latch = 0, prev_busy = 0;

   always @(negedge clk) begin
      if (rst) begin
         prev_sclk  = 0;
         prev_latch = 0;
         prev_busy  = 0;
         nbits      = 0;
         latch_run  = 0;
         busy_run   = 0;
         idle_run   = 0;
      end else begin
         if (busy) begin
            if (!prev_busy) begin
               last_gap = idle_run;
               busy_run = 0;
               nbits    = 0;
               cap      = '0;
            end
            busy_run++;
         end else begin
            if (prev_busy) begin
               last_busy = busy_run;
               idle_run  = 0;
            end
            idle_run++;
         end
         if (ser_clk && !prev_sclk) begin
            cap = {cap[46:0], ser_data};
            nbits++;
            clk_rises++;
         end
         if (ser_latch) begin
            latch_run++;
         end else if (prev_latch) begin
            last_latch = latch_run;
            latch_run  = 0;
            got_q.push_back(cap);
            bits_q.push_back(nbits);
         end
         prev_sclk  = ser_clk;
         prev_latch = ser_latch;
         prev_busy  = busy;
      end
   end

   // Bounded wait for the monitor to deliver one frame.
   task automatic wait_frame(output bit ok);
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (got_q.size() > 0) begin
            ok = 1;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic wait_busy(output bit ok);
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; raise_valid = 1'b0; raise_fin = 1'b0; raise_data = '0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({ser_data, ser_clk, ser_latch, busy} !== 4'b0000) begin
         n_err++; $display("FAIL reset_outs got %b want 0000", {ser_data, ser_clk, ser_latch, busy});
      end
      n_vec++;
      if (frame_cnt !== 8'd0) begin
         n_err++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL idle_no_valid busy got %b want 0", busy);
      end
   endtask

   task automatic test_zero_frame();
      bit ok; logic [47:0] e, g; int nb;
      raise_valid = 1'b1; raise_data = 32'h0000_0000;
      exp_q.push_back(48'h0);
      wait_frame(ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL zero_frame timeout got none want frame");
         return;
      end
      e = exp_q.pop_front(); g = got_q.pop_front(); nb = bits_q.pop_front();
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL zero_frame data got %h want %h", g, e); end
      n_vec++;
      if (nb !== 48) begin n_err++; $display("FAIL zero_frame bits got %0d want 48", nb); end
      n_vec++;
      if (last_latch !== 4) begin n_err++; $display("FAIL latch_width got %0d want 4", last_latch); end
      n_vec++;
      if (last_busy !== 197) begin n_err++; $display("FAIL busy_width got %0d want 197", last_busy); end
      n_vec++;
      if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL zero_frame_cnt got %0d want 1", frame_cnt); end
   endtask

   task automatic test_pattern();
      bit ok; logic [47:0] e, g; int nb;
      raise_data = 32'hC000_0001;
      exp_q.push_back(48'hE000_0000_0001);
      wait_frame(ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL pattern timeout got none want frame");
         return;
      end
      e = exp_q.pop_front(); g = got_q.pop_front(); nb = bits_q.pop_front();
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL pattern data got %h want %h", g, e); end
      n_vec++;
      if (nb !== 48) begin n_err++; $display("FAIL pattern bits got %0d want 48", nb); end
      n_vec++;
      if (frame_cnt !== 8'd2) begin n_err++; $display("FAIL pattern_cnt got %0d want 2", frame_cnt); end
   endtask

   task automatic test_hold();
      int rises0;
      rises0 = clk_rises;
      repeat (1000) @(negedge clk);
      n_vec++;
      if (clk_rises !== rises0) begin n_err++; $display("FAIL hold_edges got %0d want %0d", clk_rises, rises0); end
      n_vec++;
      if (frame_cnt !== 8'd2) begin n_err++; $display("FAIL hold_cnt got %0d want 2", frame_cnt); end
      n_vec++;
      if ({busy, ser_data} !== 2'b00) begin n_err++; $display("FAIL hold_idle got %b want 00", {busy, ser_data}); end
   endtask

   task automatic test_back_to_back();
      bit ok; logic [47:0] e, g;
      raise_data = 32'h0000_0003;
      exp_q.push_back(48'h0000_0000_0007);
      wait_busy(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL b2b_start busy got 0 want 1"); return; end
      repeat (50) @(negedge clk);
      raise_data = 32'h5555_5555;
      exp_q.push_back(48'h2492_4924_9249);
      for (int f = 0; f < 2; f++) begin
         wait_frame(ok);
         n_vec++;
         if (!ok) begin n_err++; $display("FAIL b2b_frame%0d timeout got none want frame", f); return; end
         e = exp_q.pop_front(); g = got_q.pop_front(); void'(bits_q.pop_front());
         n_vec++;
         if (g !== e) begin n_err++; $display("FAIL b2b_frame%0d data got %h want %h", f, g, e); end
      end
      n_vec++;
      if (last_gap !== 1) begin n_err++; $display("FAIL b2b_gap got %0d want 1", last_gap); end
      n_vec++;
      if (frame_cnt !== 8'd4) begin n_err++; $display("FAIL b2b_cnt got %0d want 4", frame_cnt); end
      repeat (300) @(negedge clk);
      n_vec++;
      if (got_q.size() !== 0) begin n_err++; $display("FAIL b2b_extra got %0d want 0", got_q.size()); end
   endtask

   task automatic test_fin();
      bit ok; logic [47:0] e, g;
      raise_fin = 1'b1; raise_data = 32'hFFFF_FFFF;
      exp_q.push_back(48'h0);
      wait_frame(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL fin timeout got none want frame"); return; end
      e = exp_q.pop_front(); g = got_q.pop_front(); void'(bits_q.pop_front());
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL fin data got %h want %h", g, e); end
      repeat (100) @(negedge clk);
      raise_data = 32'h1234_5678;
      repeat (300) @(negedge clk);
      n_vec++;
      if (frame_cnt !== 8'd5) begin n_err++; $display("FAIL fin_hold_cnt got %0d want 5", frame_cnt); end
   endtask

   task automatic test_no_valid();
      raise_fin = 1'b0; raise_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         raise_data = $urandom;
         repeat (30) @(negedge clk);
      end
      n_vec++;
      if (frame_cnt !== 8'd5) begin n_err++; $display("FAIL no_valid_cnt got %0d want 5", frame_cnt); end
      n_vec++;
      if (got_q.size() !== 0) begin n_err++; $display("FAIL no_valid_frames got %0d want 0", got_q.size()); end
   endtask

   task automatic test_reset_midframe();
      bit ok; logic [47:0] e, g; int nb;
      raise_valid = 1'b1; raise_data = 32'h0000_0003;
      wait_busy(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rst_mid_start busy got 0 want 1"); return; end
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({ser_data, ser_clk, ser_latch, busy} !== 4'b0000) begin
         n_err++; $display("FAIL rst_mid_outs got %b want 0000", {ser_data, ser_clk, ser_latch, busy});
      end
      n_vec++;
      if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL rst_mid_cnt got %0d want 0", frame_cnt); end
      n_vec++;
      if (got_q.size() !== 0) begin n_err++; $display("FAIL rst_mid_latch got %0d want 0", got_q.size()); end
      rst = 1'b0;
      exp_q.push_back(48'h0000_0000_0007);
      wait_frame(ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rst_resend timeout got none want frame"); return; end
      e = exp_q.pop_front(); g = got_q.pop_front(); nb = bits_q.pop_front();
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL rst_resend data got %h want %h", g, e); end
      n_vec++;
      if (nb !== 48) begin n_err++; $display("FAIL rst_resend bits got %0d want 48", nb); end
      n_vec++;
      if (frame_cnt !== 8'd1) begin n_err++; $display("FAIL rst_resend_cnt got %0d want 1", frame_cnt); end
   endtask

   initial begin
      rst = 1'b1; raise_valid = 1'b0; raise_fin = 1'b0; raise_data = '0;
      test_reset();
      test_zero_frame();
      test_pattern();
      test_hold();
      test_back_to_back();
      test_fin();
      test_no_valid();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
